// File: rtl/conv_feeder_if.sv
// Beat bus from conv_feeder to the convolution block's input side.
interface conv_feeder_if;
  logic              oValid;
  logic signed [7:0] oX;
  logic              oWren;
  logic [4:0]        oADDR;
  logic signed [7:0] oW;

  modport master (output oValid, oX, oWren, oADDR, oW);
  modport slave  (input  oValid, oX, oWren, oADDR, oW);
endinterface

// File: rtl/conv_feeder.sv
// Replays a stored 32x32 feature map once per output channel and loads each
// channel's 5x5 kernel during the first taps of its pass.
module conv_feeder #(
  parameter int unsigned IMG_N = 1024,
  parameter int unsigned KK    = 25,
  parameter int unsigned NCH   = 6
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iXWren,
  input  logic [9:0]        iXADDR,
  input  logic signed [7:0] iXData,
  input  logic              iWLdEn,
  input  logic [7:0]        iWLdADDR,
  input  logic signed [7:0] iWLdData,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oDone,
  conv_feeder_if.master     strm
);

  localparam logic [9:0] PixLast = 10'(IMG_N - 1);
  localparam logic [2:0] ChLast  = 3'(NCH - 1);
  localparam logic [7:0] WLast   = 8'(NCH * KK - 1);
  localparam logic [9:0] TapN    = 10'(KK);
  localparam logic [7:0] KkW     = 8'(KK);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pix_q, pix_d;   // pixel index of the beat currently on the outputs
  logic [2:0]  ch_q, ch_d;
  logic        beat;           // a beat is registered at this edge
  logic        done_d;
  logic        tap;
  logic [7:0]  widx;

  logic signed [7:0] img  [IMG_N];
  logic signed [7:0] wmem [NCH*KK];

  // Stores: written only while idle; no reset so contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (state_q == StIdle) begin
      if (iXWren) img[iXADDR] <= iXData;
      if (iWLdEn && (iWLdADDR <= WLast)) wmem[iWLdADDR] <= iWLdData;
    end
  end

  // Next state, next beat index and beat/done strobes.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    beat    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          state_d = StStream;
          pix_d   = '0;
          ch_d    = '0;
          beat    = 1'b1;
        end
      end
      StStream: begin
        if ((pix_q == PixLast) && (ch_q == ChLast)) begin
          state_d = StDone;
          pix_d   = '0;
          ch_d    = '0;
          done_d  = 1'b1;
        end else begin
          beat = 1'b1;
          if (pix_q == PixLast) begin
            pix_d = '0;
            ch_d  = ch_q + 3'd1;
          end else begin
            pix_d = pix_q + 10'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Kernel tap decode for the beat being registered.
  always_comb begin
    tap  = beat && (pix_d < TapN);
    widx = ({5'd0, ch_d} * KkW) + {3'd0, pix_d[4:0]};
  end

  // State and counter registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      pix_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
    end
  end

  // Registered outputs; reads happen before the same-edge store write lands.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      strm.oValid <= 1'b0;
      strm.oX     <= '0;
      strm.oWren  <= 1'b0;
      strm.oADDR  <= '0;
      strm.oW     <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
    end else begin
      strm.oValid <= beat;
      strm.oX     <= beat ? img[pix_d] : '0;
      strm.oWren  <= tap;
      strm.oADDR  <= tap ? pix_d[4:0] : '0;
      strm.oW     <= tap ? wmem[widx] : '0;
      oBusy       <= beat;
      oDone       <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder: expected beats are queued at start time
// from a bench-side copy of the stores and popped as the DUT emits them.
module tb_conv_feeder;

  typedef struct {
    logic signed [7:0] x;
    logic              wren;
    logic [4:0]        addr;
    logic signed [7:0] w;
  } beat_t;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iXWren = 1'b0;
  logic [9:0]        iXADDR = '0;
  logic signed [7:0] iXData = '0;
  logic              iWLdEn = 1'b0;
  logic [7:0]        iWLdADDR = '0;
  logic signed [7:0] iWLdData = '0;
  logic              iStart = 1'b1;
  logic              oBusy, oDone;

  conv_feeder_if bus ();

  conv_feeder dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iXWren   (iXWren),
    .iXADDR   (iXADDR),
    .iXData   (iXData),
    .iWLdEn   (iWLdEn),
    .iWLdADDR (iWLdADDR),
    .iWLdData (iWLdData),
    .iStart   (iStart),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .strm     (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [7:0] img_m [1024];
  logic signed [7:0] w_m   [150];
  beat_t             sb [$];

  int valid_cnt = 0, wren_cnt = 0, done_cnt = 0, beat_idx = 0;
  logic              prev_valid = 1'b0;
  logic signed [7:0] obs_x    [6144];
  logic              obs_wren [6144];
  logic [4:0]        obs_addr [6144];
  logic signed [7:0] obs_w    [6144];
  beat_t             mb;

  function automatic logic [24:0] out_vec();
    return {bus.oValid, bus.oX, bus.oWren, bus.oADDR, bus.oW, oBusy, oDone};
  endfunction

  // Monitor: pop and compare each beat, check idle outputs, record beats.
  always @(negedge iCLK) begin
    if (bus.oValid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat idx=%0d got x=%0d (required no beat)", beat_idx, bus.oX);
      end else begin
        mb = sb.pop_front();
        if ({bus.oX, bus.oWren, bus.oADDR, bus.oW, oBusy, oDone} !==
            {mb.x, mb.wren, mb.addr, mb.w, 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL beat idx=%0d got x=%0d wren=%b addr=%0d w=%0d busy=%b done=%b required x=%0d wren=%b addr=%0d w=%0d busy=1 done=0",
                   beat_idx, bus.oX, bus.oWren, bus.oADDR, bus.oW, oBusy, oDone,
                   mb.x, mb.wren, mb.addr, mb.w);
        end
      end
      if (beat_idx < 6144) begin
        obs_x[beat_idx]    = bus.oX;
        obs_wren[beat_idx] = bus.oWren;
        obs_addr[beat_idx] = bus.oADDR;
        obs_w[beat_idx]    = bus.oW;
      end
      beat_idx++;
      valid_cnt++;
      if (bus.oWren === 1'b1) wren_cnt++;
    end else begin
      n_cmp++;
      if ({bus.oX, bus.oWren, bus.oADDR, bus.oW, oBusy} !== '0) begin
        n_err++;
        $display("FAIL idle_outputs got x=%0d wren=%b addr=%0d w=%0d busy=%b required all 0",
                 bus.oX, bus.oWren, bus.oADDR, bus.oW, oBusy);
      end
    end
    if (oDone === 1'b1) begin
      done_cnt++;
      n_cmp++;
      if (sb.size() != 0 || prev_valid !== 1'b1) begin
        n_err++;
        $display("FAIL done_timing got pending=%0d prev_valid=%b required pending=0 prev_valid=1",
                 sb.size(), prev_valid);
      end
    end
    prev_valid = bus.oValid;
  end

  task automatic clear_mon();
    valid_cnt = 0;
    wren_cnt  = 0;
    done_cnt  = 0;
    beat_idx  = 0;
  endtask

  task automatic push_run();
    beat_t b;
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 1024; p++) begin
        b.x = img_m[p];
        if (p < 25) begin
          b.wren = 1'b1;
          b.addr = 5'(p);
          b.w    = w_m[c * 25 + p];
        end else begin
          b.wren = 1'b0;
          b.addr = '0;
          b.w    = '0;
        end
        sb.push_back(b);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the sampling edge.
  task automatic start_run();
    clear_mon();
    push_run();
    iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
  endtask

  // Counts cycles after the start edge until oDone is seen; -1 on timeout.
  task automatic wait_done(input int budget, output int cyc);
    bit found = 1'b0;
    cyc = -1;
    for (int c = 1; c <= budget && !found; c++) begin
      @(negedge iCLK);
      if (oDone === 1'b1) begin
        cyc   = c;
        found = 1'b1;
      end
    end
    @(posedge iCLK); #1;
  endtask

  task automatic load_stores();
    for (int i = 0; i < 1024; i++) begin
      iXWren   = 1'b1;
      iXADDR   = 10'(i);
      iXData   = 8'(i % 128);
      iWLdEn   = (i < 150);
      iWLdADDR = 8'(i);
      iWLdData = 8'(i - 75);
      @(posedge iCLK); #1;
      img_m[i] = 8'(i % 128);
      if (i < 150) w_m[i] = 8'(i - 75);
    end
    iXWren = 1'b0;
    iWLdEn = 1'b0;
  endtask

  task automatic test_reset();
    iRST   = 1'b1;
    iStart = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    n_cmp++;
    if (out_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_hold got %h required 0", out_vec());
    end
    iStart = 1'b0;
    #1;
    iRST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iCLK);
      n_cmp++;
      if (out_vec() !== '0) begin
        n_err++;
        $display("FAIL reset_release cycle=%0d got %h required 0", c, out_vec());
      end
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_beat_content();
    int cyc;
    start_run();
    wait_done(7000, cyc);
    n_cmp++;
    if (cyc < 0) begin
      n_err++;
      $display("FAIL content_done got timeout required done");
    end
    n_cmp++;
    if ({obs_x[0], obs_wren[0], obs_addr[0], obs_w[0]} !== {8'sd0, 1'b1, 5'd0, -8'sd75}) begin
      n_err++;
      $display("FAIL beat0 got x=%0d wren=%b addr=%0d w=%0d required x=0 wren=1 addr=0 w=-75",
               obs_x[0], obs_wren[0], obs_addr[0], obs_w[0]);
    end
    n_cmp++;
    if ({obs_addr[24], obs_w[24]} !== {5'd24, -8'sd51}) begin
      n_err++;
      $display("FAIL beat24 got addr=%0d w=%0d required addr=24 w=-51", obs_addr[24], obs_w[24]);
    end
    n_cmp++;
    if ({obs_x[25], obs_wren[25], obs_addr[25], obs_w[25]} !== {8'sd25, 1'b0, 5'd0, 8'sd0}) begin
      n_err++;
      $display("FAIL beat25 got x=%0d wren=%b addr=%0d w=%0d required x=25 wren=0 addr=0 w=0",
               obs_x[25], obs_wren[25], obs_addr[25], obs_w[25]);
    end
    n_cmp++;
    if ({obs_x[1024], obs_wren[1024], obs_w[1024]} !== {8'sd0, 1'b1, -8'sd50}) begin
      n_err++;
      $display("FAIL beat1024 got x=%0d wren=%b w=%0d required x=0 wren=1 w=-50",
               obs_x[1024], obs_wren[1024], obs_w[1024]);
    end
  endtask

  task automatic test_run_accounting();
    int cyc;
    start_run();
    wait_done(7000, cyc);
    repeat (5) @(posedge iCLK);
    #1;
    n_cmp++;
    if (cyc != 6145) begin
      n_err++;
      $display("FAIL done_cycle got %0d required 6145", cyc);
    end
    n_cmp++;
    if (valid_cnt != 6144) begin
      n_err++;
      $display("FAIL valid_count got %0d required 6144", valid_cnt);
    end
    n_cmp++;
    if (wren_cnt != 150) begin
      n_err++;
      $display("FAIL wren_count got %0d required 150", wren_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL done_count got %0d required 1", done_cnt);
    end
    n_cmp++;
    if (obs_x[6143] !== 8'sd127) begin
      n_err++;
      $display("FAIL last_beat_x got %0d required 127", obs_x[6143]);
    end
  endtask

  task automatic test_ignored_controls();
    int  cyc;
    bit  done_seen = 1'b0;
    start_run();
    for (int c = 1; c <= 7000 && !done_seen; c++) begin
      @(negedge iCLK);
      iXWren = (c == 10);
      iXADDR = '0;
      iXData = 8'sd99;
      iStart = (c == 500);
      if (oDone === 1'b1) begin
        iStart    = 1'b1;   // lands on the edge where the FSM is in DONE
        done_seen = 1'b1;
      end
    end
    @(posedge iCLK); #1;
    iStart = 1'b0;
    iXWren = 1'b0;
    repeat (20) @(posedge iCLK);
    #1;
    n_cmp++;
    if (!done_seen) begin
      n_err++;
      $display("FAIL ignored_done got timeout required done");
    end
    n_cmp++;
    if (valid_cnt != 6144 || done_cnt != 1) begin
      n_err++;
      $display("FAIL ignored_counts got valid=%0d done=%0d required valid=6144 done=1",
               valid_cnt, done_cnt);
    end
    start_run();
    wait_done(7000, cyc);
    n_cmp++;
    if (obs_x[0] !== 8'sd0 || cyc != 6145) begin
      n_err++;
      $display("FAIL ignored_rerun got x0=%0d done_cycle=%0d required x0=0 done_cycle=6145",
               obs_x[0], cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start_run();
    repeat (3000) @(posedge iCLK);
    #2;
    n_cmp++;
    if ({bus.oValid, bus.oX, bus.oWren} !== {1'b1, 8'sd56, 1'b0}) begin
      n_err++;
      $display("FAIL beat3000 got valid=%b x=%0d wren=%b required valid=1 x=56 wren=0",
               bus.oValid, bus.oX, bus.oWren);
    end
    #1;
    iRST = 1'b1;
    #1;
    n_cmp++;
    if (out_vec() !== '0) begin
      n_err++;
      $display("FAIL async_reset got %h required 0", out_vec());
    end
    sb.delete();
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    start_run();
    wait_done(7000, cyc);
    n_cmp++;
    if ({obs_x[0], obs_wren[0], obs_addr[0], obs_w[0]} !== {8'sd0, 1'b1, 5'd0, -8'sd75} ||
        valid_cnt != 6144) begin
      n_err++;
      $display("FAIL restart_beat0 got x=%0d wren=%b addr=%0d w=%0d beats=%0d required x=0 wren=1 addr=0 w=-75 beats=6144",
               obs_x[0], obs_wren[0], obs_addr[0], obs_w[0], valid_cnt);
    end
  endtask

  task automatic test_dropped_write_same_cycle_start();
    int cyc;
    iWLdEn   = 1'b1;
    iWLdADDR = 8'd200;
    iWLdData = 8'sd5;
    @(posedge iCLK); #1;
    clear_mon();
    push_run();
    iWLdADDR = 8'd0;
    iWLdData = 8'sd7;
    iStart   = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    iWLdEn = 1'b0;
    w_m[0] = 8'sd7;
    wait_done(7000, cyc);
    n_cmp++;
    if (obs_w[0] !== -8'sd75 || cyc != 6145) begin
      n_err++;
      $display("FAIL same_cycle_beat0 got w=%0d done_cycle=%0d required w=-75 done_cycle=6145",
               obs_w[0], cyc);
    end
    start_run();
    wait_done(7000, cyc);
    n_cmp++;
    if (obs_w[0] !== 8'sd7 || obs_w[1024] !== -8'sd50) begin
      n_err++;
      $display("FAIL next_run_weights got w0=%0d w1024=%0d required w0=7 w1024=-50",
               obs_w[0], obs_w[1024]);
    end
  endtask

  initial begin
    test_reset();
    load_stores();
    test_beat_content();
    test_run_accounting();
    test_ignored_controls();
    test_reset_mid_run();
    test_dropped_write_same_cycle_start();
    repeat (3) @(posedge iCLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
# conv_feeder

Stream sequencer that drives the input side of the `convolution` block: it holds one 32x32 signed 8-bit input feature map and six 5x5 signed 8-bit kernels in local storage. On a start pulse it replays the full map once per output channel (6 x 1024 beats). During the first 25 beats of each pass it loads that channel's kernel through the convolution's weight-write port. It replaces bench-side stimulus generation in the first-layer datapath, with its outputs wired directly to the convolution inputs.

## Interface
- `IMG_N`, 1024, pixels per feature map (32x32)
- `KK`, 25, weights per kernel (5x5)
- `NCH`, 6, output channels (passes per run)
- `iCLK`  in  1  clock, rising edge
- `iRST`  in  1  reset; one clock, asynchronous, active-high
- `iXWren`  in  1  image store write enable
- `iXADDR`  in  10  image store write address
- `iXData`  in  8  image pixel, signed
- `iWLdEn`  in  1  weight store write enable
- `iWLdADDR`  in  8  weight store write address, valid range 0..149 (ch*25+k)
- `iWLdData`  in  8  weight, signed
- `iStart`  in  1  start a run, sampled in IDLE only
- `oBusy`  out  1  high while beats are being presented
- `oDone`  out  1  one-cycle pulse after the last beat
- `oValid`  out  1  to convolution `iValid`
- `oX`  out  8  signed pixel, to convolution `iX`
- `oWren`  out  1  to convolution `iWren`
- `oADDR`  out  5  kernel tap index, to convolution `iADDR`
- `oW`  out  8  signed weight, to convolution `iW`

## Operation
- **FSM states:** IDLE, STREAM, DONE.
- **Counters:**
  - `pix` runs 0..1023.
  - `ch` runs 0..5.
  - The weight index is ch*25+pix, computed in 8 bits; maximum value 149.
- **IDLE:**
  - All stream outputs are 0.
  - On `iStart`=1, the state moves to STREAM. At the same edge, beat 0 is registered onto the outputs.
- **STREAM:** each edge registers one beat, then advances `pix`.
  - When `pix` wraps from 1023 to 0, `ch` increments.
  - After beat (ch=5, pix=1023), the next edge moves to DONE.
- **Beat content:**
  - `oValid`=1.
  - `oX`=img[pix].
  - If pix<25: `oWren`=1, `oADDR`=pix[4:0], `oW`=w[ch*25+pix].
  - Otherwise: `oWren`=0, `oADDR`=0, `oW`=0.
- **DONE:** lasts one cycle. Stream outputs are 0, `oDone`=1, `oBusy`=0. The state then returns to IDLE.
- **Stores:**
  - Register arrays, written synchronously.
  - Writes are accepted only in IDLE. Writes in STREAM or DONE are dropped.
  - A weight write with address >149 is dropped.
  - A store write and `iStart` in the same IDLE cycle: the write completes, but beat 0 uses the pre-write contents (read-before-write).
- **Ignored inputs:** `iStart` is ignored in STREAM and DONE. There is no queueing.
- **Reset:**
  - `iRST` forces state IDLE and counters 0.
  - It forces `oValid`, `oX`, `oWren`, `oADDR`, `oW`, `oBusy` and `oDone` to 0 immediately, without waiting for a clock edge. This applies mid-run as well; the run is abandoned.
  - Store contents are not reset and survive `iRST`.
- **No backpressure:** the convolution block consumes one beat per cycle unconditionally.

## Timing
- All outputs are registered.
- The first beat is visible in the cycle immediately after the edge that samples `iStart`.
- The run lasts exactly NCH*IMG_N = 6144 consecutive cycles with `oValid`=1 and no gaps. `oBusy` equals `oValid` throughout the run.
- `oWren`=1 for exactly 25 consecutive cycles at the start of each pass, 150 cycles in total.
- `oDone` is asserted in cycle 6145 after the start edge, for one cycle.
- The earliest accepted restart is the first IDLE cycle after DONE, i.e. cycle 6146.

## Test plan
- **Reset:** hold `iRST`=1 with `iStart`=1.
  - Required: every output is 0 and the state stays IDLE.
  - After releasing `iRST` with `iStart`=0: outputs stay 0.
- **Beat content:** load img[i]=(i mod 128) and w[j]=j-75, then pulse `iStart`.
  - Beat 0: `oX`=0, `oWren`=1, `oADDR`=0, `oW`=-75.
  - Beat 24: `oADDR`=24, `oW`=-51.
  - Beat 25: `oX`=25, `oWren`=0, `oADDR`=0, `oW`=0.
  - Beat 1024 (ch=1, pix=0): `oX`=0, `oWren`=1, `oW`=-50.
- **Run accounting:** count the cycles of the full run.
  - Required: 6144 `oValid` cycles, 150 `oWren` cycles.
  - Last beat: `oX`=127.
  - `oDone` asserted once, in the cycle after the last beat.
  - Mismatch count 0 when the outputs drive `convolution` and its `oY` stream is compared with the golden output file.
- **Ignored controls:** pulse `iStart` at beat 500 and again during DONE; write iXADDR=0 with data 99 at beat 10.
  - Required: beat count unaffected and no second run.
  - A following run still shows `oX`=0 at beat 0.
- **Reset mid-run:** assert `iRST` at beat 3000 (ch=2, pix=952).
  - Required: `oValid`=0 without waiting for a clock edge.
  - Restart after release: beat 0 is (ch=0, pix=0), `oW`=-75, proving the stores retained their contents.
- **Dropped write and same-cycle start:** write iWLdADDR=200 with data 5, which must be dropped; then write iWLdADDR=0 with data 7 in the same cycle as `iStart`.
  - Required: beat 0 `oW`=-75 (pre-write contents).
  - The next run's beat 0 `oW`=7.
